rtc_bus_write: RTL



---
 rtl/rtc_bus_pkg.sv | 38 +++
 rtl/rtc_phase_timer.sv | 43 ++++
 rtl/rtc_bus_write.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/rtc_bus_pkg.sv
// ============================================================================
// rtc_bus_pkg: shared state encoding, default timing and idle bus levels for
// the RTC A/D bus write engine.                                  Rev 1.0
// ============================================================================
`default_nettype none

package rtc_bus_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    A_SETUP  = 4'd1,
    A_STROBE = 4'd2,
    A_HOLD   = 4'd3,
    GAP      = 4'd4,
    D_SETUP  = 4'd5,
    D_STROBE = 4'd6,
    D_HOLD   = 4'd7,
    DONE     = 4'd8,
    RECOV    = 4'd9
  } rtc_state_e;

  localparam int T_SETUP_DEF  = 2;
  localparam int T_STROBE_DEF = 4;
  localparam int T_HOLD_DEF   = 2;
  localparam int T_GAP_DEF    = 2;
  localparam int T_RECOV_DEF  = 3;
  localparam int TW_DEF       = 4;

  localparam logic       CS_N_IDLE   = 1'b1;
  localparam logic       RD_N_IDLE   = 1'b1;
  localparam logic       WR_N_IDLE   = 1'b1;
  localparam logic       AD_IDLE     = 1'b0;
  localparam logic       AD_OE_IDLE  = 1'b0;
  localparam logic [7:0] AD_OUT_IDLE = 8'h00;

endpackage

`default_nettype wire

// File: rtl/rtc_phase_timer.sv
// ============================================================================
// rtc_phase_timer: loadable down-counter that times each bus phase; holds at
// zero until reloaded.                                            Rev 1.0
// ============================================================================
`default_nettype none

module rtc_phase_timer #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic [TW-1:0] value,
  output logic          zero
);

  logic [TW-1:0] value_q;
  logic [TW-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (value_q != '0) begin
      value_d = value_q - TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign zero  = (value_q == '0);

endmodule

`default_nettype wire

// File: rtl/rtc_bus_write.sv
// ============================================================================
// rtc_bus_write: turns each sequencer write request into an address cycle and
// a data cycle on the RTC A/D bus, then pulses fin. Macro RTC_WR_COUNT_EN adds
// a saturating completed-write counter on wr_count.               Rev 1.0
// ============================================================================
`default_nettype none

module rtc_bus_write
  import rtc_bus_pkg::*;
#(
  parameter int T_SETUP  = T_SETUP_DEF,
  parameter int T_STROBE = T_STROBE_DEF,
  parameter int T_HOLD   = T_HOLD_DEF,
  parameter int T_GAP    = T_GAP_DEF,
  parameter int T_RECOV  = T_RECOV_DEF,
  parameter int TW       = TW_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] dir,
  input  logic [7:0] dato,
  input  logic       escribe,
  input  logic       activa,
  output logic       fin,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad,
  output logic [7:0] ad_out,
  output logic       ad_oe
`ifdef RTC_WR_COUNT_EN
  ,
  output logic [15:0] wr_count
`endif
);

  localparam logic [TW-1:0] LD_SETUP  = TW'(T_SETUP - 1);
  localparam logic [TW-1:0] LD_STROBE = TW'(T_STROBE - 1);
  localparam logic [TW-1:0] LD_HOLD   = TW'(T_HOLD - 1);
  localparam logic [TW-1:0] LD_GAP    = TW'(T_GAP - 1);
  localparam logic [TW-1:0] LD_RECOV  = TW'(T_RECOV - 1);

  rtc_state_e    state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          fin_q, fin_d;
  logic          cs_n_q, cs_n_d;
  logic          rd_n_q, rd_n_d;
  logic          wr_n_q, wr_n_d;
  logic          ad_q, ad_d;
  logic [7:0]    ad_out_q, ad_out_d;
  logic          ad_oe_q, ad_oe_d;

  logic          timer_load;
  logic [TW-1:0] timer_load_val;
  logic          timer_zero;
  logic [TW-1:0] unused_timer_value;
  logic          req;

  rtc_phase_timer #(
    .TW (TW)
  ) u_phase_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_load_val),
    .value    (unused_timer_value),
    .zero     (timer_zero)
  );

  assign req = escribe && activa;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    data_d         = data_q;
    timer_load     = 1'b0;
    timer_load_val = '0;

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d        = A_SETUP;
          addr_d         = dir;
          data_d         = dato;
          timer_load     = 1'b1;
          timer_load_val = LD_SETUP;
        end
      end
      A_SETUP: if (timer_zero) begin
        state_d = A_STROBE; timer_load = 1'b1; timer_load_val = LD_STROBE;
      end
      A_STROBE: if (timer_zero) begin
        state_d = A_HOLD; timer_load = 1'b1; timer_load_val = LD_HOLD;
      end
      A_HOLD: if (timer_zero) begin
        state_d = GAP; timer_load = 1'b1; timer_load_val = LD_GAP;
      end
      GAP: if (timer_zero) begin
        state_d = D_SETUP; timer_load = 1'b1; timer_load_val = LD_SETUP;
      end
      D_SETUP: if (timer_zero) begin
        state_d = D_STROBE; timer_load = 1'b1; timer_load_val = LD_STROBE;
      end
      D_STROBE: if (timer_zero) begin
        state_d = D_HOLD; timer_load = 1'b1; timer_load_val = LD_HOLD;
      end
      D_HOLD: if (timer_zero) begin
        state_d = DONE;
      end
      DONE: begin
        state_d = RECOV; timer_load = 1'b1; timer_load_val = LD_RECOV;
      end
      RECOV: begin
        // The edge that closes recovery doubles as the first IDLE edge, so
        // back-to-back requests are spaced exactly latency + 1 + T_RECOV.
        if (timer_zero) begin
          if (req) begin
            state_d        = A_SETUP;
            addr_d         = dir;
            data_d         = dato;
            timer_load     = 1'b1;
            timer_load_val = LD_SETUP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they change on the same edge.
    fin_d    = 1'b0;
    cs_n_d   = CS_N_IDLE;
    rd_n_d   = RD_N_IDLE;
    wr_n_d   = WR_N_IDLE;
    ad_d     = AD_IDLE;
    ad_out_d = AD_OUT_IDLE;
    ad_oe_d  = AD_OE_IDLE;

    case (state_d)
      A_SETUP, A_STROBE, A_HOLD: begin
        cs_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d;
        wr_n_d   = (state_d == A_STROBE) ? 1'b0 : 1'b1;
      end
      D_SETUP, D_STROBE, D_HOLD: begin
        cs_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_d     = 1'b1;
        ad_out_d = data_d;
        wr_n_d   = (state_d == D_STROBE) ? 1'b0 : 1'b1;
      end
      DONE:    fin_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= 8'h00;
      data_q   <= 8'h00;
      fin_q    <= 1'b0;
      cs_n_q   <= CS_N_IDLE;
      rd_n_q   <= RD_N_IDLE;
      wr_n_q   <= WR_N_IDLE;
      ad_q     <= AD_IDLE;
      ad_out_q <= AD_OUT_IDLE;
      ad_oe_q  <= AD_OE_IDLE;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      fin_q    <= fin_d;
      cs_n_q   <= cs_n_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      ad_q     <= ad_d;
      ad_out_q <= ad_out_d;
      ad_oe_q  <= ad_oe_d;
    end
  end

  assign fin    = fin_q;
  assign cs_n   = cs_n_q;
  assign rd_n   = rd_n_q;
  assign wr_n   = wr_n_q;
  assign ad     = ad_q;
  assign ad_out = ad_out_q;
  assign ad_oe  = ad_oe_q;

`ifdef RTC_WR_COUNT_EN
  logic [15:0] wr_count_q, wr_count_d;

  always_comb begin
    wr_count_d = wr_count_q;
    if ((state_q == DONE) && (wr_count_q != 16'hFFFF)) begin
      wr_count_d = wr_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_count_q <= 16'h0000;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_count = wr_count_q;
`endif

endmodule

`default_nettype wire
